// File: rtl/fetch_ctrl_if.sv
// Handshake/bus bundle for fetch_ctrl.
//   master : the fetch sequencer side (drives ROM address and decode outputs)
//   slave  : the environment side (ROM data, redirect/halt control, decode ready)
// Signals:
//   im_addr/im_rd                 instruction ROM address and combinational read data
//   redirect_valid/redirect_pc    PC redirect request and target byte address
//   halt_req                      level request to stop issuing fetches
//   inst_valid/inst_ready         decode handshake
//   inst/inst_pc                  head instruction word and its byte address
//   halted/misalign               status flags
interface fetch_ctrl_if;
   logic [15:0] im_addr;
   logic [31:0] im_rd;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        halt_req;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [15:0] inst_pc;
   logic        halted;
   logic        misalign;

   modport master (
      output im_addr, inst_valid, inst, inst_pc, halted, misalign,
      input  im_rd, redirect_valid, redirect_pc, halt_req, inst_ready
   );

   modport slave (
      input  im_addr, inst_valid, inst, inst_pc, halted, misalign,
      output im_rd, redirect_valid, redirect_pc, halt_req, inst_ready
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for the rv32i core.
// Owns the fetch PC, reads the combinational instruction ROM, buffers fetched
// words in a DEPTH-entry prefetch queue and hands them to decode over a
// valid/ready handshake. Redirects flush the queue and reload the PC; halt
// requests stop new fetches while the queue keeps draining.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous reset, active low
//   bus    fetch_ctrl_if.master (ROM port, redirect/halt, decode handshake, status)
// Parameters:
//   RESET_PC  word-aligned fetch PC loaded on reset
//   DEPTH     prefetch queue entries (power of 2, >= 2)
// Build option:
//   FETCH_MISALIGN_EN  when defined, a misaligned redirect enters FAULT and raises
//                      misalign; otherwise redirect_pc[1:0] is dropped on load.
//
// state | meaning
// IDLE  | first cycle after reset release, no fetch
// RUN   | fetching into the queue whenever there is room
// HALT  | no new fetches, queue drains to decode
// FAULT | misaligned redirect taken, no fetches until an aligned redirect
module fetch_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          DEPTH    = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_ctrl_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

`ifdef FETCH_MISALIGN_EN
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2, FAULT = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
`endif

   state_t          state, state_nxt;
   logic [15:0]     fetch_pc, fetch_pc_nxt;
   logic [CW-1:0]   count, count_nxt;
   logic [PW-1:0]   rd_ptr, rd_ptr_nxt, wr_ptr, wr_ptr_nxt;
   logic [31:0]     q_word [DEPTH];
   logic [15:0]     q_pc   [DEPTH];
   logic            push, pop, redir;
   logic [15:0]     redir_pc;

`ifdef FETCH_MISALIGN_EN
   logic            redir_bad;
   assign redir_pc  = bus.redirect_pc;
   assign redir_bad = (bus.redirect_pc[1:0] != 2'b00);
`else
   assign redir_pc  = bus.redirect_pc & 16'hFFFC;
`endif

   // Redirects are ignored in IDLE; the queue is empty there anyway.
   assign redir = bus.redirect_valid && (state != IDLE);
   assign bus.inst_valid = (count != '0) && !bus.redirect_valid;
   assign pop  = bus.inst_valid && bus.inst_ready;
   // A pop frees a slot in the same cycle, so a full queue can still accept.
   assign push = (state == RUN) && !bus.halt_req && !bus.redirect_valid &&
                 ((count < CW'(DEPTH)) || pop);

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      count_nxt    = count;
      rd_ptr_nxt   = rd_ptr;
      wr_ptr_nxt   = wr_ptr;
      case (state)
         IDLE:    state_nxt = RUN;
         RUN:     if (!bus.redirect_valid && bus.halt_req)  state_nxt = HALT;
         HALT:    if (!bus.redirect_valid && !bus.halt_req) state_nxt = RUN;
`ifdef FETCH_MISALIGN_EN
         FAULT:   state_nxt = FAULT;
`endif
         default: state_nxt = IDLE;
      endcase
      if (redir) begin
         fetch_pc_nxt = redir_pc;
         count_nxt    = '0;
         rd_ptr_nxt   = '0;
         wr_ptr_nxt   = '0;
`ifdef FETCH_MISALIGN_EN
         if (redir_bad)           state_nxt = FAULT;
         else if (state == FAULT) state_nxt = bus.halt_req ? HALT : RUN;
`endif
      end else begin
         count_nxt = count + CW'(push) - CW'(pop);
         if (push) begin
            wr_ptr_nxt   = wr_ptr + PW'(1);
            fetch_pc_nxt = fetch_pc + 16'd4;
         end
         if (pop) rd_ptr_nxt = rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         count    <= count_nxt;
         rd_ptr   <= rd_ptr_nxt;
         wr_ptr   <= wr_ptr_nxt;
      end
   end

   // Entries are cleared on reset so inst/inst_pc read as zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_word[i] <= '0;
            q_pc[i]   <= '0;
         end
      end else if (push) begin
         q_word[wr_ptr] <= bus.im_rd;
         q_pc[wr_ptr]   <= fetch_pc;
      end
   end

   assign bus.im_addr = fetch_pc;
   assign bus.inst    = q_word[rd_ptr];
   assign bus.inst_pc = q_pc[rd_ptr];
   assign bus.halted  = (state == HALT) && (count == '0);
`ifdef FETCH_MISALIGN_EN
   assign bus.misalign = (state == FAULT);
`else
   assign bus.misalign = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   fetch_ctrl_if bus ();

   fetch_ctrl #(.RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [31:0] rom(input logic [15:0] a);
      case (a)
         16'h0000: rom = 32'h0000_0013;
         16'h0004: rom = 32'h0000_0093;
         16'h0008: rom = 32'h0000_0913;
         default:  rom = {a ^ 16'hA5C3, a};
      endcase
   endfunction

   assign bus.im_rd = rom(bus.im_addr);

   // Reference model: queue of fetched {pc, word}, next fetch address, mode.
   // mode: 0 idle, 1 run, 2 halt, 3 fault
   logic [15:0] mq_pc[$];
   logic [31:0] mq_w[$];
   logic [15:0] m_pc;
   int          m_mode;

   task automatic model_reset();
      mq_pc.delete();
      mq_w.delete();
      m_pc   = 16'h0000;
      m_mode = 0;
   endtask

   function automatic bit e_valid();
      return (mq_pc.size() != 0) && !bus.redirect_valid;
   endfunction

   function automatic bit e_halted();
      return (m_mode == 2) && (mq_pc.size() == 0);
   endfunction

   function automatic bit e_mis();
      return (m_mode == 3);
   endfunction

   task automatic model_step();
      bit pop;
      if (!rst_n) begin
         model_reset();
         return;
      end
      pop = e_valid() && bus.inst_ready;
      if (m_mode == 0) begin
         m_mode = 1;
      end else if (bus.redirect_valid) begin
         mq_pc.delete();
         mq_w.delete();
`ifdef FETCH_MISALIGN_EN
         m_pc = bus.redirect_pc;
         if (bus.redirect_pc[1:0] != 2'b00) m_mode = 3;
         else if (m_mode == 3)              m_mode = bus.halt_req ? 2 : 1;
`else
         m_pc = bus.redirect_pc & 16'hFFFC;
`endif
      end else begin
         if (pop) begin
            void'(mq_pc.pop_front());
            void'(mq_w.pop_front());
         end
         if (m_mode == 1 && !bus.halt_req && mq_pc.size() < DEPTH) begin
            mq_pc.push_back(m_pc);
            mq_w.push_back(rom(m_pc));
            m_pc = m_pc + 16'd4;
         end
         if (m_mode == 1 && bus.halt_req)       m_mode = 2;
         else if (m_mode == 2 && !bus.halt_req) m_mode = 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic reset_release();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Advance until a handshake completes; returns its PC, or ok=0 on timeout.
   task automatic wait_delivered(output logic [15:0] pc, output bit ok);
      ok = 1'b0;
      pc = '0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.inst_valid && bus.inst_ready) begin
            pc = bus.inst_pc;
            ok = 1'b1;
            tick();
            return;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 16'h0000;
      bus.halt_req       = 1'b0;
      bus.inst_ready     = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #2;
      checks++;
      if ({bus.im_addr, bus.inst_valid, bus.inst, bus.inst_pc, bus.halted, bus.misalign} !==
          {16'h0000, 1'b0, 32'h0, 16'h0000, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset addr=%h valid=%b inst=%h pc=%h halted=%b mis=%b required all zero",
                  bus.im_addr, bus.inst_valid, bus.inst, bus.inst_pc, bus.halted, bus.misalign);
      end
   endtask

   task automatic test_startup();
      logic [15:0] exp_pc [3] = '{16'h0000, 16'h0004, 16'h0008};
      logic [31:0] exp_w  [3] = '{32'h13, 32'h93, 32'h913};
      bus.inst_ready = 1'b1;
      reset_release();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (bus.inst_valid !== 1'b0 || bus.im_addr !== 16'h0000) begin
            failures++;
            $display("FAIL startup_idle cyc=%0d valid=%b addr=%h required 0/0000", c, bus.inst_valid, bus.im_addr);
         end
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc[k] || bus.inst !== exp_w[k]) begin
            failures++;
            $display("FAIL startup_seq k=%0d valid=%b pc=%h inst=%h required 1/%h/%h",
                     k, bus.inst_valid, bus.inst_pc, bus.inst, exp_pc[k], exp_w[k]);
         end
         tick();
      end
   endtask

   task automatic test_stall();
      logic [15:0] pc;
      bit ok;
      bus.inst_ready = 1'b0;
      reset_release();
      for (int c = 0; c < 6; c++) tick();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (bus.im_addr !== 16'h0008 || bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0000 ||
             bus.inst !== rom(16'h0000)) begin
            failures++;
            $display("FAIL stall_hold addr=%h valid=%b pc=%h inst=%h required 0008/1/0000/%h",
                     bus.im_addr, bus.inst_valid, bus.inst_pc, bus.inst, rom(16'h0000));
         end
         tick();
      end
      bus.inst_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_delivered(pc, ok);
         checks++;
         if (!ok || pc !== 16'(4 * k)) begin
            failures++;
            $display("FAIL stall_order k=%0d ok=%b pc=%h required %h", k, ok, pc, 16'(4 * k));
         end
      end
   endtask

   task automatic test_redirect();
      logic [15:0] pc;
      bit ok;
      bus.inst_ready = 1'b0;
      for (int c = 0; c < 3; c++) tick();
      bus.inst_ready     = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 16'h0014;
      @(negedge clk);
      checks++;
      if (bus.inst_valid !== 1'b0) begin
         failures++;
         $display("FAIL redirect_gate valid=%b required 0", bus.inst_valid);
      end
      tick();
      bus.redirect_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_delivered(pc, ok);
         checks++;
         if (!ok || pc !== 16'h0014 + 16'(4 * k)) begin
            failures++;
            $display("FAIL redirect_seq k=%0d ok=%b pc=%h required %h", k, ok, pc, 16'h0014 + 16'(4 * k));
         end
      end
   endtask

   task automatic test_halt();
      logic [15:0] frozen, pc;
      bit ok, seen;
      bus.inst_ready = 1'b0;
      for (int c = 0; c < 3; c++) tick();
      bus.halt_req   = 1'b1;
      bus.inst_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (bus.halted === 1'b1) seen = 1'b1;
         else tick();
      end
      checks++;
      if (!seen || bus.im_addr !== m_pc) begin
         failures++;
         $display("FAIL halt_reach halted=%b addr=%h required 1/%h", bus.halted, bus.im_addr, m_pc);
      end
      frozen = m_pc;
      for (int c = 0; c < 3; c++) begin
         tick();
         @(negedge clk);
         checks++;
         if (bus.im_addr !== frozen || bus.halted !== 1'b1 || bus.inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt_frozen addr=%h halted=%b valid=%b required %h/1/0",
                     bus.im_addr, bus.halted, bus.inst_valid, frozen);
         end
      end
      tick();
      bus.halt_req = 1'b0;
      wait_delivered(pc, ok);
      checks++;
      if (!ok || pc !== frozen) begin
         failures++;
         $display("FAIL halt_resume ok=%b pc=%h required %h", ok, pc, frozen);
      end
   endtask

   task automatic test_wrap();
      logic [15:0] exp_pc [3] = '{16'hFFF8, 16'hFFFC, 16'h0000};
      logic [15:0] pc;
      bit ok;
      bus.inst_ready     = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 16'hFFF8;
      tick();
      bus.redirect_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_delivered(pc, ok);
         checks++;
         if (!ok || pc !== exp_pc[k]) begin
            failures++;
            $display("FAIL wrap_seq k=%0d ok=%b pc=%h required %h", k, ok, pc, exp_pc[k]);
         end
      end
   endtask

   task automatic test_misalign();
      logic [15:0] pc;
      bit ok;
      bus.inst_ready     = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 16'h0102;
      tick();
      bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_EN
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (bus.misalign !== 1'b1 || bus.inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL misalign_fault mis=%b valid=%b required 1/0", bus.misalign, bus.inst_valid);
         end
         tick();
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 16'h0100;
      tick();
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.misalign !== 1'b0) begin
         failures++;
         $display("FAIL misalign_clear mis=%b required 0", bus.misalign);
      end
`endif
      wait_delivered(pc, ok);
      checks++;
      if (!ok || pc !== 16'h0100) begin
         failures++;
         $display("FAIL misalign_deliver ok=%b pc=%h required 0100", ok, pc);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         bus.inst_ready     = ($urandom_range(0, 3) != 0);
         bus.redirect_valid = ($urandom_range(0, 15) == 0);
         bus.redirect_pc    = 16'($urandom);
         if ($urandom_range(0, 3) != 0) bus.redirect_pc[1:0] = 2'b00;
         if ($urandom_range(0, 7) == 0) bus.halt_req = ~bus.halt_req;
         if (c == 200) begin
            #2;
            rst_n = 1'b0;
            model_reset();
            #1;
            checks++;
            if (bus.inst_valid !== 1'b0 || bus.im_addr !== 16'h0000 || bus.inst_pc !== 16'h0000 ||
                bus.inst !== 32'h0) begin
               failures++;
               $display("FAIL reset_mid valid=%b addr=%h pc=%h inst=%h required 0", bus.inst_valid,
                        bus.im_addr, bus.inst_pc, bus.inst);
            end
         end
         if (c == 202) rst_n = 1'b1;
         @(negedge clk);
         checks++;
         if (bus.inst_valid !== e_valid() || bus.im_addr !== m_pc || bus.halted !== e_halted() ||
             bus.misalign !== e_mis() ||
             (e_valid() && (bus.inst_pc !== mq_pc[0] || bus.inst !== mq_w[0]))) begin
            failures++;
            $display("FAIL random cyc=%0d valid=%b/%b addr=%h/%h halted=%b/%b mis=%b/%b pc=%h inst=%h",
                     c, bus.inst_valid, e_valid(), bus.im_addr, m_pc, bus.halted, e_halted(),
                     bus.misalign, e_mis(), bus.inst_pc, bus.inst);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_stall();
      test_redirect();
      test_halt();
      test_wrap();
      test_misalign();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
